nand_fb_pipe: RTL and testbench

Parametrised, multi-channel successor to the single-bit NAND/NOT feedback cell: each channel holds a registered NAND-feedback accumulator, so `acc <= ~(acc & in)` is a real clocked state rather than a combinational loop. Optionally, a channel applies a pure NOT instead. Results leave through a DEPTH-stage valid/ready pipeline. The block sits between a multi-dimensional packed-array producer and consumer in the fuzz-regression datapath.

---
 rtl/nand_fb_pkg.sv | 18 +
 rtl/nand_fb_stage.sv | 32 +++
 rtl/nand_fb_pipe.sv | 90 +++++++++
 tb/tb_nand_fb_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nand_fb_pkg.sv
// Shared types and the NAND-feedback / NOT result function for nand_fb_pipe.
package nand_fb_pkg;

    localparam int unsigned LaneW = 4;

    typedef logic [LaneW-1:0] lane_t;

    typedef struct packed {
        logic  valid;
        lane_t data;
    } stage_t;

    // Bitwise rule, so it is applied bit by bit to lanes of any width.
    function automatic logic nand_fb(input logic acc, input logic din, input logic inv);
        return inv ? ~din : ~(acc & din);
    endfunction

endpackage

// File: rtl/nand_fb_stage.sv
// One pipeline register {valid, data}; holds its contents while en_i is low.
module nand_fb_stage
    import nand_fb_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/nand_fb_pipe.sv
// Multi-channel registered NAND-feedback accumulator feeding a DEPTH-stage
// valid/ready pipeline with a single global advance.
module nand_fb_pipe
    import nand_fb_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [CHANNELS-1:0][WIDTH-1:0]     in_data_i,
    input  logic [CHANNELS-1:0]                in_inv_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [CHANNELS-1:0][WIDTH-1:0]     out_data_o,
    output logic [CHANNELS-1:0][WIDTH-1:0]     acc_o,
    output logic [CNT_W-1:0]                   beat_cnt_o
);

    localparam int unsigned DW = CHANNELS * WIDTH;

    logic                              adv;
    logic                              accept;
    logic [CHANNELS-1:0][WIDTH-1:0]    result;
    logic [CHANNELS-1:0][WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]                  beat_cnt_q, beat_cnt_d;

    logic [DEPTH:0]                    stg_valid;
    logic [DEPTH:0][DW-1:0]            stg_data;

    // The whole pipeline moves as one; a stall freezes every stage.
    assign adv        = ~out_valid_o | out_ready_i;
    assign in_ready_o = adv;
    assign accept     = in_valid_i & adv;

    always_comb begin
        result = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < WIDTH; b++) begin
                result[c][b] = nand_fb(acc_q[c][b], in_data_i[c][b], in_inv_i[c]);
            end
        end
    end

    always_comb begin
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            acc_d      = result;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign stg_valid[0] = accept;
    assign stg_data[0]  = result;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        nand_fb_stage #(
            .DW (DW)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (adv),
            .valid_i (stg_valid[k]),
            .data_i  (stg_data[k]),
            .valid_o (stg_valid[k+1]),
            .data_o  (stg_data[k+1])
        );
    end

    assign out_valid_o = stg_valid[DEPTH];
    assign out_data_o  = stg_data[DEPTH];
    assign acc_o       = acc_q;
    assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_nand_fb_pipe.sv
// Randomised and directed bench for nand_fb_pipe against a queue-based reference model.
module tb_nand_fb_pipe;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned D  = 3;
    localparam int unsigned CW = 8;

    typedef logic [CH-1:0][W-1:0] vec_t;
    typedef struct {
        bit   v;
        vec_t d;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    vec_t            in_data = '0;
    logic [CH-1:0]   in_inv = '0;
    logic            in_ready;
    logic            out_valid;
    vec_t            out_data;
    vec_t            acc;
    logic [CW-1:0]   beat_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ent_t        m_pipe[$];
    vec_t        m_acc;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    nand_fb_pipe #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .DEPTH    (D),
        .CNT_W    (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_inv_i    (in_inv),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .acc_o       (acc),
        .beat_cnt_o  (beat_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t spec_result(input vec_t a, input vec_t x, input logic [CH-1:0] inv);
        vec_t r;
        for (int c = 0; c < CH; c++) r[c] = inv[c] ? ~x[c] : ~(a[c] & x[c]);
        return r;
    endfunction

    task automatic model_reset();
        ent_t e;
        e.v = 1'b0;
        e.d = '0;
        m_pipe.delete();
        for (int i = 0; i < D; i++) m_pipe.push_back(e);
        m_acc = '0;
        m_cnt = 0;
    endtask

    // Front of the queue is the beat currently presented at the output.
    task automatic model_step();
        bit   adv;
        ent_t e;
        adv = !m_pipe[0].v || out_ready;
        e.v = in_valid && adv;
        e.d = spec_result(m_acc, in_data, in_inv);
        if (adv) begin
            void'(m_pipe.pop_front());
            m_pipe.push_back(e);
        end
        if (e.v) begin
            m_acc = e.d;
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_acc", 64'(acc), 64'(0));
        chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(!m_pipe[0].v || out_ready));
            chk("out_valid", 64'(out_valid), 64'(m_pipe[0].v));
            chk("acc", 64'(acc), 64'(m_acc));
            chk("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
            if (m_pipe[0].v) chk("out_data", 64'(out_data), 64'(m_pipe[0].d));
        end
    end

    initial begin
        vec_t saved[$];
        int   n;

        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Chain F, 5, A through the registered accumulator.
        in_valid = 1'b1;
        in_data  = {CH{4'hA}};
        in_inv   = '0;
        cycle();
        chk("beat1_acc", 64'(acc), 64'(16'hFFFF));
        chk("beat1_cnt", 64'(beat_cnt), 64'(1));
        cycle();
        chk("beat2_acc", 64'(acc), 64'(16'h5555));
        in_data = {CH{4'h5}};
        cycle();
        chk("beat3_acc", 64'(acc), 64'(16'hAAAA));
        chk("lat_valid", 64'(out_valid), 64'(1));
        chk("out_seq0", 64'(out_data), 64'(16'hFFFF));
        in_valid = 1'b0;
        cycle();
        chk("out_seq1", 64'(out_data), 64'(16'h5555));
        cycle();
        chk("out_seq2", 64'(out_data), 64'(16'hAAAA));
        cycle();
        chk("out_seq_end", 64'(out_valid), 64'(0));

        // Mixed NOT / NAND lanes from a cleared accumulator.
        do_reset();
        in_valid = 1'b1;
        in_data  = {CH{4'h3}};
        in_inv   = 4'b0101;
        cycle();
        chk("mixed_acc", 64'(acc), 64'(16'hFCFC));
        in_valid = 1'b0;
        in_inv   = '0;
        repeat (D - 1) cycle();
        chk("mixed_out_valid", 64'(out_valid), 64'(1));
        chk("mixed_out", 64'(out_data), 64'(16'hFCFC));
        cycle();

        // Back-pressure: exactly D beats enter, then the output holds.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            in_data = vec_t'($urandom);
            in_inv  = CH'($urandom);
            if (in_ready) begin
                n++;
                saved.push_back(spec_result(m_acc, in_data, in_inv));
            end
            cycle();
            if (out_valid && saved.size() > 0) chk("bp_stable", 64'(out_data), 64'(saved[0]));
        end
        chk("bp_in_flight", 64'(n), 64'(D));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int j = 0; j < D; j++) begin
            chk("drain_valid", 64'(out_valid), 64'(1));
            if (saved.size() > 0) chk("drain_data", 64'(out_data), 64'(saved.pop_front()));
            cycle();
        end
        chk("drain_end", 64'(out_valid), 64'(0));

        // Counter wrap.
        do_reset();
        in_valid = 1'b1;
        repeat (256) begin
            in_data = vec_t'($urandom);
            cycle();
        end
        chk("wrap_256", 64'(beat_cnt), 64'(0));
        cycle();
        chk("wrap_257", 64'(beat_cnt), 64'(1));

        // Reset with two beats in flight: nothing stale may emerge.
        in_valid = 1'b0;
        repeat (D) cycle();
        in_valid = 1'b1;
        repeat (2) cycle();
        do_reset();
        for (int j = 0; j <= D; j++) begin
            cycle();
            chk("no_stale", 64'(out_valid), 64'(0));
        end

        // Random traffic with occasional resets.
        repeat (3000) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_data   = vec_t'($urandom);
            in_inv    = CH'($urandom);
            cycle();
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
